reg_bank: RTL



---
 rtl/mips_regs_pkg.sv | 13 +
 rtl/reg_read_port.sv | 37 +++
 rtl/reg_bank.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_regs_pkg.sv
// Shared register-file constants and types for the multicycle MIPS datapath.
// The destination-select mux, the control FSM and reg_bank all import this package.
package mips_regs_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  localparam reg_idx_t REG_ZERO     = 5'd0;
  localparam reg_idx_t REG_SP       = 5'd29;
  localparam reg_idx_t REG_RA       = 5'd31;
  localparam word_t    SP_RESET_VAL = 32'd227;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: index select, zero-index forcing and, when
// REG_BANK_BYPASS_EN is defined, same-cycle write-through forwarding.
module reg_read_port
  import mips_regs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] read_idx,
`ifdef REG_BANK_BYPASS_EN
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] read_data
);

  logic is_zero;

  assign is_zero = (read_idx == ADDR_W'(REG_ZERO));

  always_comb begin
    read_data = regs[read_idx];
`ifdef REG_BANK_BYPASS_EN
    // Forward the in-flight write; a write being discarded by reset must not leak through.
    if (wr_en && !reset && (wr_idx == read_idx)) begin
      read_data = wr_data;
    end
`endif
    if (is_zero) begin
      read_data = '0;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32 MIPS general-purpose register file: synchronous write, two combinational reads.
// Optional write-through forwarding on the read ports is enabled by REG_BANK_BYPASS_EN.
module reg_bank
  import mips_regs_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_IDX   = int'(REG_SP),
  parameter int SP_RESET = int'(SP_RESET_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register 0 has no storage at all, so it can never hold anything but zero.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        localparam logic [DATA_W-1:0] RST_VAL =
          (gi == SP_IDX) ? DATA_W'(SP_RESET) : '0;

        logic [DATA_W-1:0] value_reg;

        always_ff @(posedge clk) begin
          if (reset) begin
            value_reg <= RST_VAL;
          end else if (RegWrite && (WriteReg == ADDR_W'(gi))) begin
            value_reg <= WriteData;
          end
        end

        assign regs[gi] = value_reg;
      end
    end
  endgenerate

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .regs      (regs),
    .read_idx  (ReadReg1),
`ifdef REG_BANK_BYPASS_EN
    .reset     (reset),
    .wr_en     (RegWrite),
    .wr_idx    (WriteReg),
    .wr_data   (WriteData),
`endif
    .read_data (ReadData1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .regs      (regs),
    .read_idx  (ReadReg2),
`ifdef REG_BANK_BYPASS_EN
    .reset     (reset),
    .wr_en     (RegWrite),
    .wr_idx    (WriteReg),
    .wr_data   (WriteData),
`endif
    .read_data (ReadData2)
  );

endmodule
